// File: rtl/ram_if_pkg.sv
// Shared definitions for the single-port RAM initiator: default widths,
// depth and the burst master state encoding.
package ram_if_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_DATA
    } ram_bm_state_t;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address generator: holds the current address and the remaining
// beat count. Shared by the write and read paths of the burst master.
module ram_burst_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last
);

    logic [ADDR_W-1:0] cur_addr_reg;
    logic [ADDR_W-1:0] remain_reg;

    // Load on command accept, step address/count on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_reg <= '0;
            remain_reg   <= '0;
        end else if (load) begin
            cur_addr_reg <= load_addr;
            remain_reg   <= load_len;
        end else if (advance) begin
            // Address wraps modulo the RAM depth; the count stops at zero
            // because the burst ends on the beat taken with remain == 0.
            cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
            if (remain_reg != '0) begin
                remain_reg <= remain_reg - ADDR_W'(1);
            end
        end
    end

    assign cur_addr  = cur_addr_reg;
    assign next_addr = cur_addr_reg + ADDR_W'(1);
    assign last      = (remain_reg == '0);

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a synchronous single-port RAM with registered read
// address. Write bursts stream beats straight into the RAM; read bursts
// return RAM output on a valid/ready stream with back-pressure.
module ram_burst_master
    import ram_if_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    ram_bm_state_t state_reg;
    ram_bm_state_t state_next;

    logic              load;
    logic              advance;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              last;

    ram_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .advance   (advance),
        .cur_addr  (cur_addr),
        .next_addr (next_addr),
        .last      (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and outputs. All control outputs are forced low while rst
    // is high so a reset mid-burst cannot issue one more RAM write.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        busy       = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        load       = 1'b0;
        advance    = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        load       = 1'b1;
                        state_next = cmd_write ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: begin
                    busy     = 1'b1;
                    wr_ready = 1'b1;
                    ram_addr = cur_addr;
                    ram_we   = wr_valid;
                    if (wr_valid) begin
                        advance = 1'b1;
                        if (last) begin
                            state_next = IDLE;
                        end
                    end
                end
                RD_ISSUE: begin
                    busy       = 1'b1;
                    ram_addr   = cur_addr;
                    state_next = RD_DATA;
                end
                RD_DATA: begin
                    busy     = 1'b1;
                    rd_valid = 1'b1;
                    rd_last  = last;
                    if (rd_ready) begin
                        // Issue the following beat in the same cycle so a
                        // continuously ready consumer gets one beat per cycle.
                        ram_addr = next_addr;
                        advance  = 1'b1;
                        if (last) begin
                            state_next = IDLE;
                        end
                    end else begin
                        // Re-latch the same address so ram_q stays stable.
                        ram_addr = cur_addr;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign ram_data = wr_data;
    assign rd_data  = ram_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: a behavioural 64x8 RAM on the
// ram_* pins, a reference memory image, and a scoreboard monitor.
module tb_ram_burst_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [64];
    logic [7:0]  wdata   [64];
    logic [13:0] wr_q [$];
    logic [8:0]  rd_q [$];

    ram_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // Behavioural single-port RAM: write on we, otherwise latch read address.
    logic       ram_init;
    logic [7:0] ram_mem [64];
    logic [5:0] ram_addr_q;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 8'(i * 37 + 5);
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_data;
        end else begin
            ram_addr_q <= ram_addr;
        end
    end
    assign ram_q = ram_mem[ram_addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: pops expected writes/read beats as the DUT shows them.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [13:0] we_exp;
        logic [8:0]  rd_exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs", {26'd0, cmd_ready, wr_ready, rd_valid, rd_last, busy, ram_we}, 32'd0);
                prev_stall = 1'b0;
            end else begin
                check("busy_vs_cmd_ready", {31'd0, busy}, {31'd0, ~cmd_ready});
                if (ram_we) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ram_write_extra actual addr=%0d data=0x%0h expected no write", ram_addr, ram_data);
                    end else begin
                        we_exp = wr_q.pop_front();
                        check("ram_write", {18'd0, ram_addr, ram_data}, {18'd0, we_exp});
                    end
                end
                if (prev_stall) begin
                    check("rd_hold", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, prev_data});
                end
                if (rd_valid && rd_ready) begin
                    if (rd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_beat_extra actual data=0x%0h expected no beat", rd_data);
                    end else begin
                        rd_exp = rd_q.pop_front();
                        check("rd_beat", {23'd0, rd_last, rd_data}, {23'd0, rd_exp});
                    end
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
            end
        end
    end

    // Offer a command and wait (bounded) for the accept edge.
    task automatic accept_cmd(input logic wr, input logic [5:0] a, input logic [5:0] l, output bit ok);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", {31'd0, ok}, 32'd1);
    endtask

    // mode 0: every cycle valid, 1: LSB-first pattern then all ones, 2: random
    function automatic logic pick(input int mode, input logic [15:0] pat, input int pat_n, input int k);
        if (mode == 1) return (k < pat_n) ? pat[k] : 1'b1;
        if (mode == 2) return ($urandom % 3) != 0;
        return 1'b1;
    endfunction

    task automatic write_burst(input logic [5:0] a, input logic [5:0] l, input int mode,
                               input logic [15:0] pat, input int pat_n);
        bit ok;
        int i, cyc, n;
        logic v;
        logic [5:0] wa;
        accept_cmd(1'b1, a, l, ok);
        if (!ok) return;
        n = int'(l) + 1;
        i = 0;
        cyc = 0;
        // A command offered while busy must be ignored.
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = 6'($urandom);
        while (i < n && cyc < 1000) begin
            v = pick(mode, pat, pat_n, cyc);
            wr_valid = v;
            wr_data  = wdata[i];
            if (v) begin
                wa = 6'(int'(a) + i);
                wr_q.push_back({wa, wdata[i]});
                ref_mem[wa] = wdata[i];
            end
            @(negedge clk);
            check("wr_ready", {31'd0, wr_ready}, 32'd1);
            @(posedge clk); #1;
            if (v) i++;
            cyc++;
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'b0;
        if (cyc >= 1000) check("write_timeout", cyc, 32'd0);
        @(negedge clk);
        check("write_done_idle", {30'd0, busy, cmd_ready}, 32'd1);
    endtask

    task automatic read_burst(input logic [5:0] a, input logic [5:0] l, input int mode,
                              input logic [15:0] pat, input int pat_n);
        bit ok;
        int cnt, cyc, n;
        logic r;
        logic [5:0] ra;
        accept_cmd(1'b0, a, l, ok);
        if (!ok) return;
        n = int'(l) + 1;
        for (int i = 0; i < n; i++) begin
            ra = 6'(int'(a) + i);
            rd_q.push_back({(i == n - 1), ref_mem[ra]});
        end
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = 6'($urandom);
        rd_ready  = 1'($urandom);
        @(negedge clk);
        check("rd_issue_cycle", {30'd0, rd_valid, busy}, 32'd1);
        @(posedge clk); #1;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 1000) begin
            r = pick(mode, pat, pat_n, cyc);
            rd_ready = r;
            @(negedge clk);
            check("rd_valid", {31'd0, rd_valid}, 32'd1);
            @(posedge clk); #1;
            if (r) cnt++;
            cyc++;
        end
        rd_ready  = 1'b0;
        cmd_valid = 1'b0;
        if (cyc >= 1000) check("read_timeout", cyc, 32'd0);
        @(negedge clk);
        check("read_done_idle", {30'd0, busy, cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst = 1'b1;
        ram_init = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_cmd_ready", {30'd0, busy, cmd_ready}, 32'd1);

        // Contiguous write then read.
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        write_burst(6'd10, 6'd3, 0, 16'h0, 0);
        read_burst(6'd10, 6'd3, 0, 16'h0, 0);

        // Wrap at the top of the address space.
        for (int i = 0; i < 4; i++) wdata[i] = 8'(8'hA0 + i);
        write_burst(6'd62, 6'd3, 0, 16'h0, 0);
        read_burst(6'd62, 6'd3, 0, 16'h0, 0);

        // Read back-pressure, rd_ready 1,0,0,1,0,1,1.
        read_burst(6'd10, 6'd3, 1, 16'b1101001, 7);

        // Write gaps, wr_valid 1,0,1,0,0,1.
        for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
        write_burst(6'd20, 6'd2, 1, 16'b100101, 6);
        read_burst(6'd20, 6'd2, 0, 16'h0, 0);

        // Full depth.
        for (int i = 0; i < 64; i++) wdata[i] = 8'(i) ^ 8'h5A;
        write_burst(6'd0, 6'd63, 0, 16'h0, 0);
        read_burst(6'd0, 6'd63, 0, 16'h0, 0);

        // Reset after the 2nd beat of a 6-beat write at 30.
        accept_cmd(1'b1, 6'd30, 6'd5, ok);
        if (ok) begin
            wr_valid = 1'b1;
            wr_data = 8'hC0;
            wr_q.push_back({6'd30, 8'hC0});
            ref_mem[30] = 8'hC0;
            @(posedge clk); #1;
            wr_data = 8'hC1;
            wr_q.push_back({6'd31, 8'hC1});
            ref_mem[31] = 8'hC1;
            @(posedge clk); #1;
            rst = 1'b1;
            wr_data = 8'hC2;
            cmd_valid = 1'b1;
            @(negedge clk);
            check("rst_ram_we", {31'd0, ram_we}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            wr_valid = 1'b0;
            cmd_valid = 1'b0;
            @(negedge clk);
            check("after_rst_cmd_ready", {30'd0, busy, cmd_ready}, 32'd1);
        end
        read_burst(6'd28, 6'd9, 0, 16'h0, 0);

        // Randomized bursts.
        for (int t = 0; t < 25; t++) begin
            logic [5:0] ra, rl;
            ra = 6'($urandom);
            rl = 6'($urandom % 16);
            if ($urandom % 2) begin
                for (int i = 0; i < 64; i++) wdata[i] = 8'($urandom);
                write_burst(ra, rl, 2, 16'h0, 0);
            end else begin
                read_burst(ra, rl, 2, 16'h0, 0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("wr_q_empty", wr_q.size(), 32'd0);
        check("rd_q_empty", rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
